// File: rtl/ascon_arbiter.sv
// Round-robin arbiter sharing one ascon_core between NREQ requesters for whole operations.
// Mode and data-type fields are 4 bits wide, matching the core's e_mode / e_data_type encodings.
module ascon_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned CCW  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ-1:0][3:0]          req_mode_i,
    input  logic [NREQ-1:0][CCW-1:0]      req_key_i,
    input  logic [NREQ-1:0]               req_key_valid_i,
    output logic [NREQ-1:0]               req_key_ready_o,
    input  logic [NREQ-1:0][CCW-1:0]      req_bdi_i,
    input  logic [NREQ-1:0][CCW/8-1:0]    req_bdi_valid_i,
    input  logic [NREQ-1:0][3:0]          req_bdi_type_i,
    input  logic [NREQ-1:0]               req_bdi_eot_i,
    input  logic [NREQ-1:0]               req_bdi_eoi_i,
    output logic [NREQ-1:0]               req_bdi_ready_o,
    output logic [CCW-1:0]                req_bdo_o,
    output logic [3:0]                    req_bdo_type_o,
    output logic                          req_bdo_eot_o,
    output logic [NREQ-1:0]               req_bdo_valid_o,
    input  logic [NREQ-1:0]               req_bdo_ready_i,
    input  logic [NREQ-1:0]               req_bdo_eoo_i,

    output logic [NREQ-1:0]               gnt_o,
    output logic [NREQ-1:0]               done_o,
    output logic                          auth_o,
    output logic [NREQ-1:0]               auth_valid_o,

    input  logic                          cfg_upd_i,
    input  logic [20:0]                   cfg_data_i,
    output logic                          cfg_ack_o,

    output logic [3:0]                    core_mode_o,
    output logic [CCW-1:0]                core_key_o,
    output logic                          core_key_valid_o,
    output logic [CCW-1:0]                core_bdi_o,
    output logic [CCW/8-1:0]              core_bdi_valid_o,
    output logic [3:0]                    core_bdi_type_o,
    output logic                          core_bdi_eot_o,
    output logic                          core_bdi_eoi_o,
    output logic                          core_bdo_ready_o,
    output logic                          core_bdo_eoo_o,
    input  logic                          core_key_ready_i,
    input  logic                          core_bdi_ready_i,
    input  logic [CCW-1:0]                core_bdo_i,
    input  logic                          core_bdo_valid_i,
    input  logic [3:0]                    core_bdo_type_i,
    input  logic                          core_bdo_eot_i,
    input  logic                          core_auth_i,
    input  logic                          core_auth_valid_i,
    input  logic                          core_done_i,
    output logic                          core_upd_sbox_o,
    output logic [20:0]                   core_sbox_data_o
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StStart,
        StBusy,
        StRelease
    } state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IdxW-1:0]   gidx_q;
    logic [IdxW-1:0]   rr_q;
    logic [3:0]        mode_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   auth_valid_q;
    logic              auth_q;
    logic              auth_prev_q;
    logic              cfg_ack_q;
    logic              upd_q;
    logic [20:0]       sbox_q;

    logic [NREQ-1:0]   elig;
    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    logic              route;

    // M_NONE requests are never eligible for a grant.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_i[i] && (req_mode_i[i] != 4'd0);
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int unsigned j;
            j = (int'(rr_q) + k) % NREQ;
            if (!pick_valid && elig[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(j);
            end
        end
    end

    assign route = (state_q == StStart) || (state_q == StBusy);

    always_comb begin
        core_key_o       = req_key_i[gidx_q];
        core_key_valid_o = route & req_key_valid_i[gidx_q];
        core_bdi_o       = req_bdi_i[gidx_q];
        core_bdi_valid_o = route ? req_bdi_valid_i[gidx_q] : '0;
        core_bdi_type_o  = req_bdi_type_i[gidx_q];
        core_bdi_eot_o   = route & req_bdi_eot_i[gidx_q];
        core_bdi_eoi_o   = route & req_bdi_eoi_i[gidx_q];
        core_bdo_ready_o = route & req_bdo_ready_i[gidx_q];
        core_bdo_eoo_o   = route & req_bdo_eoo_i[gidx_q];
        req_key_ready_o  = route ? (gnt_q & {NREQ{core_key_ready_i}}) : '0;
        req_bdi_ready_o  = route ? (gnt_q & {NREQ{core_bdi_ready_i}}) : '0;
        req_bdo_valid_o  = route ? (gnt_q & {NREQ{core_bdo_valid_i}}) : '0;
    end

    assign req_bdo_o        = core_bdo_i;
    assign req_bdo_type_o   = core_bdo_type_i;
    assign req_bdo_eot_o    = core_bdo_eot_i;
    assign gnt_o            = gnt_q;
    assign done_o           = done_q;
    assign auth_o           = auth_q;
    assign auth_valid_o     = auth_valid_q;
    assign cfg_ack_o        = cfg_ack_q;
    assign core_mode_o      = mode_q;
    assign core_upd_sbox_o  = upd_q;
    assign core_sbox_data_o = sbox_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            gidx_q       <= '0;
            rr_q         <= '0;
            mode_q       <= '0;
            done_q       <= '0;
            auth_valid_q <= '0;
            auth_q       <= 1'b0;
            auth_prev_q  <= 1'b0;
            cfg_ack_q    <= 1'b0;
            upd_q        <= 1'b0;
            sbox_q       <= '0;
        end else begin
            auth_valid_q <= '0;
            cfg_ack_q    <= 1'b0;
            upd_q        <= 1'b0;
            auth_prev_q  <= core_auth_valid_i;
            unique case (state_q)
                StIdle: begin
                    // A pending S-box update wins over new operations.
                    if (cfg_upd_i) begin
                        upd_q     <= 1'b1;
                        cfg_ack_q <= 1'b1;
                        sbox_q    <= cfg_data_i;
                        state_q   <= StCfg;
                    end else if (pick_valid) begin
                        gidx_q  <= pick_idx;
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        mode_q  <= req_mode_i[pick_idx];
                        state_q <= StStart;
                    end
                end
                StCfg: begin
                    state_q <= StIdle;
                end
                StStart: begin
                    mode_q  <= '0;
                    state_q <= StBusy;
                end
                StBusy: begin
                    if (core_auth_valid_i && !auth_prev_q) begin
                        auth_valid_q <= gnt_q;
                        auth_q       <= core_auth_i;
                    end
                    if (core_done_i) begin
                        done_q  <= gnt_q;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    rr_q    <= (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter; the core side is emulated by driving core_* inputs directly.
module tb_ascon_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned CCW  = 32;

    logic                        clk;
    logic                        rst_n;
    logic [NREQ-1:0]             req_i;
    logic [NREQ-1:0][3:0]        req_mode_i;
    logic [NREQ-1:0][CCW-1:0]    req_key_i;
    logic [NREQ-1:0]             req_key_valid_i;
    logic [NREQ-1:0]             req_key_ready_o;
    logic [NREQ-1:0][CCW-1:0]    req_bdi_i;
    logic [NREQ-1:0][CCW/8-1:0]  req_bdi_valid_i;
    logic [NREQ-1:0][3:0]        req_bdi_type_i;
    logic [NREQ-1:0]             req_bdi_eot_i;
    logic [NREQ-1:0]             req_bdi_eoi_i;
    logic [NREQ-1:0]             req_bdi_ready_o;
    logic [CCW-1:0]              req_bdo_o;
    logic [3:0]                  req_bdo_type_o;
    logic                        req_bdo_eot_o;
    logic [NREQ-1:0]             req_bdo_valid_o;
    logic [NREQ-1:0]             req_bdo_ready_i;
    logic [NREQ-1:0]             req_bdo_eoo_i;
    logic [NREQ-1:0]             gnt_o;
    logic [NREQ-1:0]             done_o;
    logic                        auth_o;
    logic [NREQ-1:0]             auth_valid_o;
    logic                        cfg_upd_i;
    logic [20:0]                 cfg_data_i;
    logic                        cfg_ack_o;
    logic [3:0]                  core_mode_o;
    logic [CCW-1:0]              core_key_o;
    logic                        core_key_valid_o;
    logic [CCW-1:0]              core_bdi_o;
    logic [CCW/8-1:0]            core_bdi_valid_o;
    logic [3:0]                  core_bdi_type_o;
    logic                        core_bdi_eot_o;
    logic                        core_bdi_eoi_o;
    logic                        core_bdo_ready_o;
    logic                        core_bdo_eoo_o;
    logic                        core_key_ready_i;
    logic                        core_bdi_ready_i;
    logic [CCW-1:0]              core_bdo_i;
    logic                        core_bdo_valid_i;
    logic [3:0]                  core_bdo_type_i;
    logic                        core_bdo_eot_i;
    logic                        core_auth_i;
    logic                        core_auth_valid_i;
    logic                        core_done_i;
    logic                        core_upd_sbox_o;
    logic [20:0]                 core_sbox_data_o;

    int total = 0;
    int bad   = 0;

    ascon_arbiter #(.NREQ(NREQ), .CCW(CCW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_i             (req_i),
        .req_mode_i        (req_mode_i),
        .req_key_i         (req_key_i),
        .req_key_valid_i   (req_key_valid_i),
        .req_key_ready_o   (req_key_ready_o),
        .req_bdi_i         (req_bdi_i),
        .req_bdi_valid_i   (req_bdi_valid_i),
        .req_bdi_type_i    (req_bdi_type_i),
        .req_bdi_eot_i     (req_bdi_eot_i),
        .req_bdi_eoi_i     (req_bdi_eoi_i),
        .req_bdi_ready_o   (req_bdi_ready_o),
        .req_bdo_o         (req_bdo_o),
        .req_bdo_type_o    (req_bdo_type_o),
        .req_bdo_eot_o     (req_bdo_eot_o),
        .req_bdo_valid_o   (req_bdo_valid_o),
        .req_bdo_ready_i   (req_bdo_ready_i),
        .req_bdo_eoo_i     (req_bdo_eoo_i),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .auth_o            (auth_o),
        .auth_valid_o      (auth_valid_o),
        .cfg_upd_i         (cfg_upd_i),
        .cfg_data_i        (cfg_data_i),
        .cfg_ack_o         (cfg_ack_o),
        .core_mode_o       (core_mode_o),
        .core_key_o        (core_key_o),
        .core_key_valid_o  (core_key_valid_o),
        .core_bdi_o        (core_bdi_o),
        .core_bdi_valid_o  (core_bdi_valid_o),
        .core_bdi_type_o   (core_bdi_type_o),
        .core_bdi_eot_o    (core_bdi_eot_o),
        .core_bdi_eoi_o    (core_bdi_eoi_o),
        .core_bdo_ready_o  (core_bdo_ready_o),
        .core_bdo_eoo_o    (core_bdo_eoo_o),
        .core_key_ready_i  (core_key_ready_i),
        .core_bdi_ready_i  (core_bdi_ready_i),
        .core_bdo_i        (core_bdo_i),
        .core_bdo_valid_i  (core_bdo_valid_i),
        .core_bdo_type_i   (core_bdo_type_i),
        .core_bdo_eot_i    (core_bdo_eot_i),
        .core_auth_i       (core_auth_i),
        .core_auth_valid_i (core_auth_valid_i),
        .core_done_i       (core_done_i),
        .core_upd_sbox_o   (core_upd_sbox_o),
        .core_sbox_data_o  (core_sbox_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One whole operation by requester r; the request must already be pending in IDLE.
    task automatic op(input int r, input logic [3:0] m, input logic aval, input logic keep,
                      input logic cfg);
        int n;
        logic [63:0] oh;
        oh = 64'(1) << r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_o == '0 && n < 10);
        chk("gnt_latency", 64'(n), 64'd1);
        chk("start_gnt", 64'(gnt_o), oh);
        chk("start_mode", 64'(core_mode_o), 64'(m));
        chk("start_key", 64'(core_key_o), 64'(32'hA000_0000 + 32'(r)));
        chk("start_key_valid", 64'(core_key_valid_o), 64'd1);
        chk("start_key_ready", 64'(req_key_ready_o), oh);
        chk("start_bdi_valid", 64'(core_bdi_valid_o), 64'hF);
        @(negedge clk);
        chk("busy_mode", 64'(core_mode_o), 64'd0);
        chk("busy_bdi", 64'(core_bdi_o), 64'(32'hB000_0000 + 32'(r)));
        chk("busy_bdi_type", 64'(core_bdi_type_o), 64'(r + 1));
        chk("busy_bdi_ready", 64'(req_bdi_ready_o), oh);
        chk("busy_bdo_valid", 64'(req_bdo_valid_o), oh);
        chk("busy_bdo", 64'(req_bdo_o), 64'h0000_0000_C0DE_0001);
        req_bdo_ready_i = NREQ'(oh);
        req_bdo_eoo_i   = ~NREQ'(oh);
        #1;
        chk("busy_bdo_ready", 64'(core_bdo_ready_o), 64'd1);
        chk("busy_bdo_eoo", 64'(core_bdo_eoo_o), 64'd0);
        if (cfg) begin
            cfg_upd_i  = 1'b1;
            cfg_data_i = 21'h1ABCD;
        end
        core_auth_valid_i = 1'b1;
        core_auth_i       = aval;
        @(negedge clk);
        chk("auth_valid", 64'(auth_valid_o), oh);
        chk("auth_val", 64'(auth_o), 64'(aval));
        chk("busy_ack", 64'(cfg_ack_o), 64'd0);
        @(negedge clk);
        chk("auth_one_pulse", 64'(auth_valid_o), 64'd0);
        core_auth_valid_i = 1'b0;
        core_done_i       = 1'b1;
        @(negedge clk);
        chk("rel_done", 64'(done_o), oh);
        chk("rel_gnt", 64'(gnt_o), oh);
        chk("rel_ack", 64'(cfg_ack_o), 64'd0);
        core_done_i = 1'b0;
        if (!keep) req_i[r] = 1'b0;
        @(negedge clk);
        chk("idle_done", 64'(done_o), 64'd0);
        chk("idle_gnt", 64'(gnt_o), 64'd0);
        chk("idle_ack", 64'(cfg_ack_o), 64'd0);
        chk("idle_upd", 64'(core_upd_sbox_o), 64'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        req_i             = '0;
        req_mode_i        = '0;
        req_key_valid_i   = '1;
        req_bdi_eot_i     = 2'b10;
        req_bdi_eoi_i     = 2'b01;
        req_bdo_ready_i   = '0;
        req_bdo_eoo_i     = '0;
        cfg_upd_i         = 1'b0;
        cfg_data_i        = '0;
        core_key_ready_i  = 1'b1;
        core_bdi_ready_i  = 1'b1;
        core_bdo_i        = 32'hC0DE_0001;
        core_bdo_valid_i  = 1'b1;
        core_bdo_type_i   = 4'd3;
        core_bdo_eot_i    = 1'b0;
        core_auth_i       = 1'b0;
        core_auth_valid_i = 1'b0;
        core_done_i       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_key_i[i]       = 32'hA000_0000 + 32'(i);
            req_bdi_i[i]       = 32'hB000_0000 + 32'(i);
            req_bdi_valid_i[i] = 4'hF;
            req_bdi_type_i[i]  = 4'(i + 1);
        end

        #12;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_auth_valid", 64'(auth_valid_o), 64'd0);
        chk("rst_auth", 64'(auth_o), 64'd0);
        chk("rst_ack", 64'(cfg_ack_o), 64'd0);
        chk("rst_mode", 64'(core_mode_o), 64'd0);
        chk("rst_upd", 64'(core_upd_sbox_o), 64'd0);
        chk("rst_key_valid", 64'(core_key_valid_o), 64'd0);
        chk("rst_bdi_valid", 64'(core_bdi_valid_o), 64'd0);
        chk("rst_bdo_valid", 64'(req_bdo_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester encrypt.
        req_mode_i[0] = 4'd1;
        req_mode_i[1] = 4'd2;
        req_i = 2'b01;
        op(0, 4'd1, 1'b1, 1'b0, 1'b0);

        // Contention from a fresh reset; requester 1 decrypts with a bad tag.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 2'b11;
        op(0, 4'd1, 1'b1, 1'b0, 1'b0);
        op(1, 4'd2, 1'b0, 1'b0, 1'b0);

        // Fairness with both requesters held high.
        req_i = 2'b11;
        op(0, 4'd1, 1'b1, 1'b1, 1'b0);
        op(1, 4'd2, 1'b1, 1'b1, 1'b0);
        op(0, 4'd1, 1'b1, 1'b1, 1'b0);
        op(1, 4'd2, 1'b1, 1'b0, 1'b0);

        // Config raised mid-operation is deferred until after release.
        req_i[1] = 1'b1;
        op(0, 4'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("cfg_ack", 64'(cfg_ack_o), 64'd1);
        chk("cfg_upd", 64'(core_upd_sbox_o), 64'd1);
        chk("cfg_data", 64'(core_sbox_data_o), 64'h1ABCD);
        chk("cfg_no_gnt", 64'(gnt_o), 64'd0);
        cfg_upd_i = 1'b0;
        @(negedge clk);
        chk("cfg_upd_once", 64'(core_upd_sbox_o), 64'd0);
        chk("cfg_ack_once", 64'(cfg_ack_o), 64'd0);
        chk("cfg_still_no_gnt", 64'(gnt_o), 64'd0);
        op(1, 4'd2, 1'b1, 1'b0, 1'b0);

        // M_NONE request never receives a grant.
        req_mode_i[0] = 4'd0;
        req_i = 2'b01;
        repeat (3) @(negedge clk);
        chk("illegal_no_gnt", 64'(gnt_o), 64'd0);
        req_i[1] = 1'b1;
        op(1, 4'd2, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("illegal_still_no_gnt", 64'(gnt_o), 64'd0);
        req_i = 2'b00;
        req_mode_i[0] = 4'd1;

        // Asynchronous reset while BUSY.
        @(negedge clk);
        req_i = 2'b01;
        @(negedge clk);
        chk("pre_rst_gnt", 64'(gnt_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        req_i = 2'b00;
        #1;
        chk("arst_gnt", 64'(gnt_o), 64'd0);
        chk("arst_mode", 64'(core_mode_o), 64'd0);
        chk("arst_key_valid", 64'(core_key_valid_o), 64'd0);
        chk("arst_bdi_valid", 64'(core_bdi_valid_o), 64'd0);
        chk("arst_bdo_valid", 64'(req_bdo_valid_o), 64'd0);
        chk("arst_bdi_ready", 64'(req_bdi_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 2'b10;
        op(1, 4'd2, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
